mixcol_sched: RTL and testbench
===============================

# mixcol_sched

Column-serial MixColumns engine for the iterative AES round datapath. It accepts a 128-bit state over a valid/ready handshake and applies MixColumns one 32-bit column per cycle through a single shared `mixcolumn` instance. This cuts column-mixer area by 4x against the fully parallel `mixcolumns`. It sits between ShiftRows and AddRoundKey and provides a bypass for the final round, which has no MixColumns.

## Interface
Parameters:
- `NCOL`, 4: columns per state; fixed for AES-128, exposed only for the cycle-count constant.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  input  1  rising-edge clock
- `rst_n`  input  1  asynchronous active-low reset
- `in_valid`  input  1  `in_state` and `in_bypass` are valid
- `in_ready`  output  1  block can accept a state
- `in_state`  input  128  state; column c = bits [127-32c -: 32], byte r of a column = bits [31-8r -: 8]
- `in_bypass`  input  1  final round; pass state through unmixed
- `out_valid`  output  1  `out_state` holds a result
- `out_ready`  input  1  downstream accepts the result
- `out_state`  output  128  result state, same packing as `in_state`
- `busy`  output  1  state machine not in IDLE

## Operation
- FSM states are IDLE, RUN and DONE.
- Registers: `st_q` [127:0], `col_q` [1:0], `byp_q`.
- IDLE
  - `in_ready`=1.
  - On `in_valid`: load `st_q`←`in_state` and set `col_q`=0.
  - If `in_bypass`=1, go to DONE. Otherwise go to RUN.
- RUN
  - Each cycle, column `col_q` of `st_q` feeds the shared `mixcolumn`. Its output overwrites that column of `st_q`; the other columns hold.
  - `col_q` increments each cycle. After column 3 (`col_q`=3), go to DONE.
  - `in_ready`=0.
- DONE
  - `out_valid`=1 and `out_state`=`st_q`. Both hold stable until `out_ready`.
  - On `out_ready`=1, the result is consumed. `in_ready`=`out_ready` in this state, so a new accept can happen in the same cycle.
    - Simultaneous `out_ready` and `in_valid`: load the new state, then go to RUN or DONE per `in_bypass`.
    - `out_ready` alone: go to IDLE.
- `out_state` is driven from `st_q` in every state. It is meaningful only while `out_valid`=1.
- GF(2^8) arithmetic uses the existing `mixcolumn`/`galoismult` with polynomial 0x11B. No width growth occurs; every column result is exactly 32 bits.
- Inputs are ignored while `in_ready`=0. Holding `in_valid` high across RUN has no effect.

## Timing
- Reset (`rst_n`=0, asynchronous) puts the block in IDLE with `st_q`=0, `col_q`=0, `byp_q`=0.
- Reset values of outputs: `out_valid`=0, `out_state`=0, `busy`=0.
- `in_ready` is decoded from state, so it reads 1 in IDLE after reset. Handshakes while `rst_n`=0 are discarded.
- Reset mid-RUN or mid-DONE aborts the operation with no output. The first cycle after release is IDLE.
- Mixed latency: accept at edge 0, columns 0..3 processed at edges 1..4, `out_valid`=1 after edge 4. That is 5 cycles from accept to `out_valid`.
- Bypass latency: `out_valid`=1 after edge 0, i.e. 1 cycle.
- Throughput:
  - Mixed states: one per 5 cycles when `out_ready` is tied high, using the same-cycle DONE→accept path.
  - Bypass states: one per cycle.
- Backpressure: DONE holds indefinitely. No result is ever dropped or overwritten while `out_valid`=1 and `out_ready`=0.
- All outputs are registered or decoded only from the FSM state. There is no combinational path from input to output except `in_ready`←`out_ready` in DONE.

## Structure
- `aes_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, RUN, DONE} mixsched_state_t`
  - `localparam COL_W = 32`
  - `localparam NCOL = 4`
- One sub-module, the existing `mixcolumn`, instantiated once. It is the only GF logic in the block.
- Column select and writeback use `col_q`-indexed part-selects. There is no per-column replication.

## Test plan
- FIPS-197 App. B round 1: `in_state`=d4bf5d30e0b452aeb84111f11e2798e5, `in_bypass`=0, `out_ready`=1 → `out_state`=046681e5e0cb199a48f8d37a2806264c with `out_valid` rising exactly 5 cycles after accept.
- Known columns: input db135345_f20a225c_01010101_c6c6c6c6 → output 8e4da1bc_9fdc589d_01010101_c6c6c6c6.
- Bypass: `in_bypass`=1 with the App. B input → identical state out 1 cycle after accept. Then issue 4 back-to-back bypass states with `out_ready`=1 → one output per cycle, in order.
- Backpressure: `out_ready`=0 for 20 cycles after DONE → `out_valid` and `out_state` stable, `in_ready`=0. Release `out_ready` together with a new `in_valid` → new state accepted that cycle, and the next result arrives 5 cycles later.
- Reset mid-RUN: drop `rst_n` at `col_q`=2 → immediately `out_valid`=0, `busy`=0, `out_state`=0. After release, a fresh App. B input gives the correct result.
- Random: 1000 random states with random `in_bypass`, `in_valid` and `out_ready` against the 4-parallel `mixcolumns` model → all match, in order, none lost or duplicated.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES datapath types, widths and GF(2^8) helpers.
package aes_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} mixsched_state_t;

  localparam int unsigned COL_W = 32;
  localparam int unsigned NCOL  = 4;

  // Multiply by x in GF(2^8) modulo 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/mixcolumn.sv
// Single-column AES MixColumns: circulant (02 03 01 01) over GF(2^8).
module mixcolumn (
  input  logic [31:0] col_in,
  output logic [31:0] col_out
);
  import aes_pkg::*;

  logic [7:0] a0, a1, a2, a3;
  logic [7:0] x0, x1, x2, x3;

  assign {a0, a1, a2, a3} = col_in;
  assign x0 = xtime(a0);
  assign x1 = xtime(a1);
  assign x2 = xtime(a2);
  assign x3 = xtime(a3);

  assign col_out[31:24] = x0 ^ x1 ^ a1 ^ a2 ^ a3;
  assign col_out[23:16] = a0 ^ x1 ^ x2 ^ a2 ^ a3;
  assign col_out[15:8]  = a0 ^ a1 ^ x2 ^ x3 ^ a3;
  assign col_out[7:0]   = x0 ^ a0 ^ a1 ^ a2 ^ x3;

endmodule

// File: rtl/mixcol_sched.sv
// Column-serial MixColumns engine: one column per cycle through a shared mixer,
// with a bypass path for the final AES round.
module mixcol_sched #(
  parameter int unsigned NCOL = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_bypass,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);
  import aes_pkg::*;

  mixsched_state_t state_q, state_d;
  logic [127:0]    st_q;
  logic [1:0]      col_q;
  logic            byp_q;

  logic             accept;
  logic [1:0]       col_last;
  logic [6:0]       col_lsb;
  logic [COL_W-1:0] col_in, col_out;

  assign col_last = 2'(NCOL - 1);
  // Column 0 sits in the top bits, so the bit offset counts down with col_q.
  assign col_lsb  = 7'((col_last - col_q) * COL_W);
  assign col_in   = st_q[col_lsb +: COL_W];

  mixcolumn u_mixcolumn (
    .col_in  (col_in),
    .col_out (col_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = in_bypass ? DONE : RUN;
      end
      RUN: begin
        if (col_q == col_last) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        // Consuming the result frees the register in the same cycle.
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) state_d = in_bypass ? DONE : RUN;
          else          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept    = in_valid & in_ready;
  assign busy      = (state_q != IDLE);
  assign out_state = st_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= '0;
      col_q <= '0;
      byp_q <= 1'b0;
    end else if (accept) begin
      st_q  <= in_state;
      col_q <= '0;
      byp_q <= in_bypass;
    end else if (state_q == RUN && !byp_q) begin
      st_q[col_lsb +: COL_W] <= col_out;
      col_q                  <= col_q + 2'd1;
    end
  end

endmodule

// File: tb/tb_mixcol_sched.sv
// Scoreboard bench for mixcol_sched: directed FIPS-197 vectors, latency,
// backpressure, reset abort and randomized handshakes.
module tb_mixcol_sched;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         in_bypass;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;

  int unsigned  n_vec = 0;
  int unsigned  n_err = 0;
  int unsigned  n_out = 0;
  logic [127:0] sb[$];
  logic         hold_v = 1'b0;
  logic [127:0] hold_s;

  localparam logic [127:0] APPB_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] APPB_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [127:0] COLS_IN  = 128'hdb135345f20a225c01010101c6c6c6c6;
  localparam logic [127:0] COLS_OUT = 128'h8e4da1bc9fdc589d01010101c6c6c6c6;

  always #5 clk = ~clk;

  mixcol_sched #(.NCOL(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .in_bypass (in_bypass),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [127:0] mix_model(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a[4];
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) a[k] = s[127 - 32*c - 8*k -: 8];
      for (int k = 0; k < 4; k++)
        r[127 - 32*c - 8*k -: 8] = gmul(8'h02, a[k]) ^ gmul(8'h03, a[(k+1)%4])
                                   ^ a[(k+2)%4] ^ a[(k+3)%4];
    end
    return r;
  endfunction

  // Inputs are set at a negedge; sample 1 ns later, then move to the next negedge.
  task automatic cyc(output logic ov);
    logic [127:0] exp;
    #1;
    ov = out_valid;
    if (hold_v) begin
      check("hold_valid", 128'(out_valid), 128'd1);
      check("hold_state", out_state, hold_s);
    end
    hold_v = out_valid && !out_ready;
    hold_s = out_state;
    if (out_valid && out_ready) begin
      n_out++;
      if (sb.size() == 0) check("sb_underflow", 128'(sb.size()), 128'd1);
      else begin
        exp = sb.pop_front();
        check("sb_data", out_state, exp);
      end
    end
    if (rst_n && in_valid && in_ready)
      sb.push_back(in_bypass ? in_state : mix_model(in_state));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_out(input string tag, input int exp_lat);
    logic ov;
    int   lat = 0;
    do begin
      cyc(ov);
      lat++;
    end while (!ov && lat < 30);
    check({tag, "_lat"}, 128'(lat), 128'(exp_lat));
  endtask

  task automatic send(input string tag, input logic [127:0] s, input logic byp,
                      input int exp_lat);
    logic ov;
    in_state  = s;
    in_bypass = byp;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    cyc(ov);
    in_valid  = 1'b0;
    wait_out(tag, exp_lat);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic         ov;
    logic [127:0] saved;
    int unsigned  base;
    int unsigned  guard;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_state  = '0;
    in_bypass = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_busy",      128'(busy),      128'd0);
    check("rst_out_state", out_state,       128'd0);
    check("rst_in_ready",  128'(in_ready),  128'd1);
    rst_n = 1'b1;
    @(negedge clk);

    send("appb", APPB_IN, 1'b0, 5);
    check("appb_value", out_state, APPB_OUT);
    send("cols", COLS_IN, 1'b0, 5);
    check("cols_value", out_state, COLS_OUT);
    send("byp", APPB_IN, 1'b1, 1);
    check("byp_value", out_state, APPB_IN);

    // Back-to-back bypass: one result per cycle after the first accept.
    base      = n_out;
    out_ready = 1'b1;
    in_bypass = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_state = {$urandom, $urandom, $urandom, $urandom};
      cyc(ov);
      if (i > 0) check("b2b_ov", 128'(ov), 128'd1);
    end
    in_valid = 1'b0;
    cyc(ov);
    check("b2b_last_ov", 128'(ov), 128'd1);
    check("b2b_count", 128'(n_out - base), 128'd4);

    // Backpressure: result parked in DONE while out_ready is low.
    in_state  = {$urandom, $urandom, $urandom, $urandom};
    in_bypass = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    cyc(ov);
    in_valid = 1'b0;
    wait_out("bp_fill", 5);
    saved = out_state;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_state = {$urandom, $urandom, $urandom, $urandom};
      cyc(ov);
      check("bp_valid",    128'(out_valid), 128'd1);
      check("bp_state",    out_state,       saved);
      check("bp_in_ready", 128'(in_ready),  128'd0);
    end
    in_state  = COLS_IN;
    out_ready = 1'b1;
    cyc(ov);
    in_valid = 1'b0;
    wait_out("bp_next", 5);
    check("bp_next_value", out_state, COLS_OUT);

    // Reset while the third column is being mixed.
    in_state  = COLS_IN;
    in_bypass = 1'b0;
    in_valid  = 1'b1;
    cyc(ov);
    in_valid = 1'b0;
    cyc(ov);
    cyc(ov);
    check("mid_busy", 128'(busy), 128'd1);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 128'(out_valid), 128'd0);
    check("abort_busy",      128'(busy),      128'd0);
    check("abort_out_state", out_state,       128'd0);
    sb.delete();
    hold_v = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send("post_rst", APPB_IN, 1'b0, 5);
    check("post_rst_value", out_state, APPB_OUT);

    // Random traffic against the parallel model.
    for (int i = 0; i < 1000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_bypass = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_state  = {$urandom, $urandom, $urandom, $urandom};
      cyc(ov);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    guard     = 0;
    while ((sb.size() != 0 || busy) && guard < 20) begin
      cyc(ov);
      guard++;
    end
    check("drain_empty", 128'(sb.size()), 128'd0);
    check("drain_idle",  128'(busy),      128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
